// File: rtl/colocar_barcos.sv
// Ship placement stage: latches the selected ship count, then lets the player place
// ships largest first on a TAM x TAM occupancy board with bounds and overlap checks.
module colocar_barcos #(
  parameter int TAM        = 5,
  parameter int MAX_BARCOS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         cantidadBarcosSeleccionada,
  input  logic               seleccionListo,
  input  logic [2:0]         fila,
  input  logic [2:0]         columna,
  input  logic               horizontal,
  input  logic               botonColocar,
  output logic [TAM*TAM-1:0] tablero,
  output logic [2:0]         barcosColocados,
  output logic [2:0]         barcoActual,
  output logic               colocacionError,
  output logic               colocacionLista
);

  typedef enum logic [1:0] {
    ESPERA,
    COLOCANDO,
    LISTO
  } estado_t;

  localparam logic [3:0] TAM4  = 4'(TAM);
  localparam logic [2:0] MAXB3 = 3'(MAX_BARCOS);

  estado_t            estado, estado_n;
  logic [TAM*TAM-1:0] tablero_n;
  logic [2:0]         colocados_n;
  logic [2:0]         cantidad, cantidad_n;
  logic               error_n;
  logic               botonPrev;
  logic               press;
  logic [3:0]         len;
  logic [3:0]         fila4, col4;
  logic [TAM*TAM-1:0] mascara;
  logic               valido;

  assign press           = botonColocar & ~botonPrev;
  assign barcoActual     = (estado == COLOCANDO) ? (cantidad - barcosColocados) : '0;
  assign colocacionLista = (estado == LISTO);
  assign len             = {1'b0, barcoActual};
  assign fila4           = {1'b0, fila};
  assign col4            = {1'b0, columna};

  // Cells the current ship would cover; 4-bit arithmetic keeps fila+len from wrapping.
  always_comb begin
    mascara = '0;
    for (int unsigned r = 0; r < TAM; r++) begin
      for (int unsigned c = 0; c < TAM; c++) begin
        if (horizontal) begin
          if (4'(r) == fila4 && 4'(c) >= col4 && 4'(c) < col4 + len)
            mascara[r*TAM+c] = 1'b1;
        end else begin
          if (4'(c) == col4 && 4'(r) >= fila4 && 4'(r) < fila4 + len)
            mascara[r*TAM+c] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valido = (fila4 < TAM4) && (col4 < TAM4) && ((tablero & mascara) == '0);
    if (horizontal) begin
      if (col4 + len > TAM4) valido = 1'b0;
    end else begin
      if (fila4 + len > TAM4) valido = 1'b0;
    end
  end

  always_comb begin
    estado_n    = estado;
    tablero_n   = tablero;
    colocados_n = barcosColocados;
    cantidad_n  = cantidad;
    error_n     = 1'b0;
    case (estado)
      ESPERA: begin
        if (seleccionListo && cantidadBarcosSeleccionada >= 3'd1 &&
            cantidadBarcosSeleccionada <= MAXB3) begin
          cantidad_n = cantidadBarcosSeleccionada;
          estado_n   = COLOCANDO;
        end
      end
      COLOCANDO: begin
        if (press) begin
          if (valido) begin
            tablero_n   = tablero | mascara;
            colocados_n = barcosColocados + 3'd1;
            if (colocados_n == cantidad) estado_n = LISTO;
          end else begin
            error_n = 1'b1;
          end
        end
      end
      LISTO:   ;
      default: estado_n = ESPERA;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado          <= ESPERA;
      tablero         <= '0;
      barcosColocados <= '0;
      cantidad        <= '0;
      colocacionError <= 1'b0;
      botonPrev       <= 1'b0;
    end else begin
      estado          <= estado_n;
      tablero         <= tablero_n;
      barcosColocados <= colocados_n;
      cantidad        <= cantidad_n;
      colocacionError <= error_n;
      botonPrev       <= botonColocar;
    end
  end

endmodule

// File: tb/tb_colocar_barcos.sv
// Directed bench for colocar_barcos (TAM=5, MAX_BARCOS=5) with hand-computed expectations.
module tb_colocar_barcos;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  cantidadBarcosSeleccionada;
  logic        seleccionListo;
  logic [2:0]  fila, columna;
  logic        horizontal;
  logic        botonColocar;
  logic [24:0] tablero;
  logic [2:0]  barcosColocados;
  logic [2:0]  barcoActual;
  logic        colocacionError;
  logic        colocacionLista;

  int unsigned ncmp  = 0;
  int unsigned nfail = 0;

  colocar_barcos #(.TAM(5), .MAX_BARCOS(5)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .cantidadBarcosSeleccionada (cantidadBarcosSeleccionada),
    .seleccionListo             (seleccionListo),
    .fila                       (fila),
    .columna                    (columna),
    .horizontal                 (horizontal),
    .botonColocar               (botonColocar),
    .tablero                    (tablero),
    .barcosColocados            (barcosColocados),
    .barcoActual                (barcoActual),
    .colocacionError            (colocacionError),
    .colocacionLista            (colocacionLista)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [24:0] t, input logic [2:0] n,
                           input logic [2:0] a, input logic e, input logic l);
    check({tag, ".tablero"}, 32'(tablero), 32'(t));
    check({tag, ".colocados"}, 32'(barcosColocados), 32'(n));
    check({tag, ".actual"}, 32'(barcoActual), 32'(a));
    check({tag, ".error"}, 32'(colocacionError), 32'(e));
    check({tag, ".lista"}, 32'(colocacionLista), 32'(l));
  endtask

  // Drives a one-cycle press; returns sampled just after the capturing edge.
  task automatic press(input logic [2:0] f, input logic [2:0] c, input logic h);
    fila = f; columna = c; horizontal = h; botonColocar = 1'b1;
    @(negedge clk);
  endtask

  task automatic release_btn();
    botonColocar = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; cantidadBarcosSeleccionada = '0; seleccionListo = 1'b0;
    fila = '0; columna = '0; horizontal = 1'b0; botonColocar = 1'b0;
    #12;
    check_all("reset", 25'h0, 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // 1: press while waiting is ignored
    press(3'd0, 3'd0, 1'b1);
    check_all("t1", 25'h0, 3'd0, 3'd0, 1'b0, 1'b0);
    release_btn();

    // 2: out-of-range count stays waiting, then count 3 accepted
    cantidadBarcosSeleccionada = 3'd6; seleccionListo = 1'b1;
    @(negedge clk); @(negedge clk);
    check_all("t2_cnt6", 25'h0, 3'd0, 3'd0, 1'b0, 1'b0);
    cantidadBarcosSeleccionada = 3'd3;
    @(negedge clk);
    check_all("t2_cnt3", 25'h0, 3'd0, 3'd3, 1'b0, 1'b0);
    seleccionListo = 1'b0; cantidadBarcosSeleccionada = 3'd1;
    @(negedge clk);
    check("t2_latch", 32'(barcoActual), 32'd3);

    // 3: horizontal len 3 at (0,0), then hold
    press(3'd0, 3'd0, 1'b1);
    check_all("t3", 25'h7, 3'd1, 3'd2, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check_all("t3_hold", 25'h7, 3'd1, 3'd2, 1'b0, 1'b0);
    release_btn();

    // 4: overlap, out of bounds (column), out of range row
    press(3'd0, 3'd1, 1'b0);
    check_all("t4_overlap", 25'h7, 3'd1, 3'd2, 1'b1, 1'b0);
    release_btn();
    check("t4_pulse_end", 32'(colocacionError), 32'd0);
    press(3'd4, 3'd4, 1'b1);
    check_all("t4_oob", 25'h7, 3'd1, 3'd2, 1'b1, 1'b0);
    release_btn();
    press(3'd5, 3'd0, 1'b1);
    check_all("t4_row5", 25'h7, 3'd1, 3'd2, 1'b1, 1'b0);
    release_btn();
    press(3'd4, 3'd0, 1'b0);
    check_all("t4_vedge", 25'h7, 3'd1, 3'd2, 1'b1, 1'b0);
    release_btn();

    // 5: vertical at (1,4) -> bits 9,14; horizontal len1 at (4,0) -> bit 20
    press(3'd1, 3'd4, 1'b0);
    check_all("t5_v", 25'h4207, 3'd2, 3'd1, 1'b0, 1'b0);
    release_btn();
    press(3'd4, 3'd0, 1'b1);
    check_all("t5_last", 25'h104207, 3'd3, 3'd0, 1'b0, 1'b1);
    release_btn();
    press(3'd2, 3'd2, 1'b1);
    check_all("t5_ignored", 25'h104207, 3'd3, 3'd0, 1'b0, 1'b1);
    release_btn();
    seleccionListo = 1'b1; cantidadBarcosSeleccionada = 3'd5;
    @(negedge clk); @(negedge clk);
    check_all("t5_stay", 25'h104207, 3'd3, 3'd0, 1'b0, 1'b1);

    // 6: new game, partial placement, asynchronous reset between edges
    reset = 1'b0; #1; reset = 1'b1;
    cantidadBarcosSeleccionada = 3'd2;
    @(negedge clk);
    seleccionListo = 1'b0;
    check("t6_start", 32'(barcoActual), 32'd2);
    press(3'd2, 3'd0, 1'b1);
    check_all("t6_place", 25'hC00, 3'd1, 3'd1, 1'b0, 1'b0);
    release_btn();
    #2 reset = 1'b0;
    #1;
    check_all("t6_async", 25'h0, 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check_all("t6_espera", 25'h0, 3'd0, 3'd0, 1'b0, 1'b0);
    seleccionListo = 1'b1; cantidadBarcosSeleccionada = 3'd2;
    @(negedge clk);
    check("t6_rearm", 32'(barcoActual), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
